// File: rtl/rtc_bus_sequencer.sv
// Two-requester arbiter and phase sequencer for the multiplexed RTC address/data bus.
// Every non-idle phase lasts PHASE_CYCLES clocks; all bus strobes are registered.
//
// state   | meaning
// IDLE    | bus released, requests sampled and arbitrated
// A_SET   | chip selected, address driven (a_d=0)
// A_STB   | address strobe (wr_n low)
// A_HLD   | address hold, strobe released
// D_SET   | data phase setup (a_d=1); bus driven for writes, released for reads
// D_STB   | data strobe (wr_n or rd_n low); read data captured on exit
// D_HLD   | data hold, strobes released
// RECOVER | chip deselected; ack/valid pulses in the first cycle
module rtc_bus_sequencer #(
   parameter int PHASE_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   input  logic       rd_req,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   input  logic [7:0] ad_in,
   output logic       cs_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic       a_d
);

   typedef enum logic [2:0] {
      IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, RECOVER
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(PHASE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] addr_q;
   logic [7:0] data_q;
   logic       op_rd_q;
   logic       last_rd_q;
   logic       grant;
   logic       grant_rd;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      grant    = 1'b0;
      grant_rd = 1'b0;
      if (state_q == IDLE) begin
         if (wr_req || rd_req) begin
            grant    = 1'b1;
            // Under contention the read wins only if the previous grant was a write.
            grant_rd = rd_req && !(wr_req && last_rd_q);
            state_d  = A_SET;
            cnt_d    = CNT_LOAD;
         end
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end else begin
         cnt_d = CNT_LOAD;
         case (state_q)
            A_SET:   state_d = A_STB;
            A_STB:   state_d = A_HLD;
            A_HLD:   state_d = D_SET;
            D_SET:   state_d = D_STB;
            D_STB:   state_d = D_HLD;
            D_HLD:   state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Bus outputs are decoded from state_q and registered, so they trail the state by one clock.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         addr_q    <= 8'd0;
         data_q    <= 8'd0;
         op_rd_q   <= 1'b0;
         last_rd_q <= 1'b1;
         rd_data   <= 8'd0;
         busy      <= 1'b0;
         wr_ack    <= 1'b0;
         rd_valid  <= 1'b0;
         cs_n      <= 1'b1;
         wr_n      <= 1'b1;
         rd_n      <= 1'b1;
         a_d       <= 1'b0;
         ad_oe     <= 1'b0;
         ad_out    <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (grant) begin
            addr_q    <= grant_rd ? rd_addr : wr_addr;
            data_q    <= wr_data;
            op_rd_q   <= grant_rd;
            last_rd_q <= grant_rd;
         end
         if (state_q == D_STB && cnt_q == 8'd0 && op_rd_q) begin
            rd_data <= ad_in;
         end
         busy     <= (state_q != IDLE);
         wr_ack   <= 1'b0;
         rd_valid <= 1'b0;
         case (state_q)
            A_SET, A_STB, A_HLD: begin
               cs_n   <= 1'b0;
               wr_n   <= (state_q != A_STB);
               rd_n   <= 1'b1;
               a_d    <= 1'b0;
               ad_oe  <= 1'b1;
               ad_out <= addr_q;
            end
            D_SET, D_STB, D_HLD: begin
               cs_n  <= 1'b0;
               wr_n  <= !(state_q == D_STB && !op_rd_q);
               rd_n  <= !(state_q == D_STB && op_rd_q);
               a_d   <= 1'b1;
               ad_oe <= !op_rd_q;
               if (!op_rd_q) begin
                  ad_out <= data_q;
               end
            end
            RECOVER: begin
               cs_n  <= 1'b1;
               wr_n  <= 1'b1;
               rd_n  <= 1'b1;
               a_d   <= 1'b0;
               ad_oe <= 1'b0;
               if (cnt_q == CNT_LOAD) begin
                  wr_ack   <= !op_rd_q;
                  rd_valid <= op_rd_q;
               end
            end
            default: begin
               cs_n  <= 1'b1;
               wr_n  <= 1'b1;
               rd_n  <= 1'b1;
               a_d   <= 1'b0;
               ad_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer at PHASE_CYCLES=2: per-cycle strobe tables,
// arbitration order, mid-transaction requester changes and asynchronous reset abort.
module tb_rtc_bus_sequencer;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       wr_req = 1'b0;
   logic [7:0] wr_addr = 8'd0;
   logic [7:0] wr_data = 8'd0;
   logic       wr_ack;
   logic       rd_req = 1'b0;
   logic [7:0] rd_addr = 8'd0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic [7:0] ad_in = 8'hAA;
   logic       cs_n;
   logic       wr_n;
   logic       rd_n;
   logic       a_d;

   int n_vec = 0;
   int n_err = 0;

   // Expected {cs_n,wr_n,rd_n,a_d,ad_oe,wr_ack,rd_valid,busy} for the 15 cycles after busy rises.
   localparam logic [7:0] WR_TBL [15] = '{8'h69, 8'h69, 8'h29, 8'h29, 8'h69, 8'h69, 8'h79, 8'h79,
                                          8'h39, 8'h39, 8'h79, 8'h79, 8'hE5, 8'hE1, 8'hE0};
   localparam logic [7:0] RD_TBL [15] = '{8'h69, 8'h69, 8'h29, 8'h29, 8'h69, 8'h69, 8'h71, 8'h71,
                                          8'h51, 8'h51, 8'h71, 8'h71, 8'hE3, 8'hE1, 8'hE0};

   rtc_bus_sequencer #(.PHASE_CYCLES(2)) dut (
      .CLK(CLK), .RESET(RESET),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .busy(busy), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
      .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a_d(a_d)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      chk("inv_dual_strobe", 32'(!(wr_n == 1'b0 && rd_n == 1'b0)), 32'd1);
      chk("inv_strobe_no_cs", 32'(!((wr_n == 1'b0 || rd_n == 1'b0) && cs_n == 1'b1)), 32'd1);
      chk("inv_oe_during_rd", 32'(!(rd_n == 1'b0 && ad_oe == 1'b1)), 32'd1);
   end

   task automatic run_txn(input bit is_rd, input logic [7:0] addr, input logic [7:0] data,
                          input bit b2b, input int drop_at, input bit disturb);
      int waited = 0;
      logic [7:0] exp;
      @(negedge CLK);
      while (!busy && waited < 40) begin
         waited++;
         @(negedge CLK);
      end
      if (!busy) begin
         chk("busy_timeout", 32'(busy), 32'd1);
         return;
      end
      if (b2b) chk("idle_gap", 32'(waited), 32'd0);
      for (int k = 1; k <= 15; k++) begin
         if (k > 1) @(negedge CLK);
         exp = is_rd ? RD_TBL[k-1] : WR_TBL[k-1];
         chk($sformatf("ctl_%s_k%0d", is_rd ? "rd" : "wr", k),
             32'({cs_n, wr_n, rd_n, a_d, ad_oe, wr_ack, rd_valid, busy}), 32'(exp));
         if (exp[3]) chk($sformatf("ad_out_k%0d", k), 32'(ad_out), 32'((k <= 6) ? addr : data));
         if (is_rd && k == 13) chk("rd_data_valid", 32'(rd_data), 32'(data));
         if (k == 9) ad_in = is_rd ? data : 8'hAA;
         if (k == 10) ad_in = 8'hAA;
         if (disturb && k == 3) begin
            wr_req  = 1'b0;
            wr_addr = 8'h00;
         end
         if (k == drop_at) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int waited;
      int acks;

      repeat (3) @(negedge CLK);
      chk("reset_ctl", 32'({cs_n, wr_n, rd_n, a_d, ad_oe, wr_ack, rd_valid, busy}), 32'hE0);
      chk("reset_ad_out", 32'(ad_out), 32'h00);
      chk("reset_rd_data", 32'(rd_data), 32'h00);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);

      // Single write
      wr_addr = 8'h21; wr_data = 8'h45; wr_req = 1'b1;
      run_txn(1'b0, 8'h21, 8'h45, 1'b0, 13, 1'b0);

      // Single read
      repeat (2) @(negedge CLK);
      rd_addr = 8'h22; rd_req = 1'b1;
      run_txn(1'b1, 8'h22, 8'h37, 1'b0, 13, 1'b0);
      repeat (3) @(negedge CLK);
      chk("rd_data_hold", 32'(rd_data), 32'h37);

      // Contention: write, read, write, back to back
      wr_addr = 8'h30; wr_data = 8'h59; rd_addr = 8'h31;
      wr_req = 1'b1; rd_req = 1'b1;
      run_txn(1'b0, 8'h30, 8'h59, 1'b0, 0, 1'b0);
      run_txn(1'b1, 8'h31, 8'h5A, 1'b1, 0, 1'b0);
      run_txn(1'b0, 8'h30, 8'h59, 1'b1, 1, 1'b0);
      chk("rd_data_after_wr", 32'(rd_data), 32'h5A);

      // Request dropped and address changed during A_STB
      repeat (2) @(negedge CLK);
      wr_addr = 8'h21; wr_data = 8'h66; wr_req = 1'b1;
      run_txn(1'b0, 8'h21, 8'h66, 1'b0, 13, 1'b1);

      // Asynchronous reset during write D_STB
      repeat (2) @(negedge CLK);
      wr_addr = 8'h44; wr_data = 8'h12; wr_req = 1'b1;
      waited = 0;
      @(negedge CLK);
      while (!busy && waited < 40) begin
         waited++;
         @(negedge CLK);
      end
      chk("rst_busy_seen", 32'(busy), 32'd1);
      repeat (8) @(negedge CLK);
      chk("rst_pre_wr_n", 32'(wr_n), 32'd0);
      #1 RESET = 1'b1;
      #1;
      chk("rst_async_cs_n", 32'(cs_n), 32'd1);
      chk("rst_async_wr_n", 32'(wr_n), 32'd1);
      chk("rst_async_ad_oe", 32'(ad_oe), 32'd0);
      chk("rst_async_busy", 32'(busy), 32'd0);
      wr_req = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (wr_ack) acks++;
      end
      chk("rst_no_ack", 32'(acks), 32'd0);
      wr_addr = 8'h21; wr_data = 8'h45; wr_req = 1'b1;
      run_txn(1'b0, 8'h21, 8'h45, 1'b0, 13, 1'b0);

      repeat (2) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
